// File: rtl/main_mem_loader.sv
// main_mem_loader: packs a byte stream into 32-bit accelerator RAM writes, starts the accelerator and times the run.
// Optional watchdog on the run length: define LOADER_TIMEOUT_EN.
module main_mem_loader #(
    parameter int MEM_BYTES      = 128,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [31:0]       S_Wdata_ram,
    output logic [6:0]        S_data_ram_size,
    output logic              start_port,
    input  logic              done_port,
    output logic              res_valid,
    input  logic              res_ack,
    output logic [31:0]       sim_cycles,
    output logic              overrun,
    output logic              timeout
);
    localparam int WORDS = MEM_BYTES / 4;
    localparam int WI_W  = $clog2(WORDS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, RUN, REPORT} state_t;

    state_t            state_q, state_d;
    logic [31:0]       lane_q, lane_d, cnt_q, cnt_d, cnt_inc, wdata;
    logic [1:0]        lane_idx_q, lane_idx_d;
    logic [WI_W-1:0]   word_idx_q, word_idx_d;
    logic              overrun_q, overrun_d, in_ready_q, start_q, res_valid_q;
    logic              we, accept, in_window;
    logic [ADDR_W-1:0] addr;

    assign accept    = in_valid && in_ready_q;
    assign in_window = word_idx_q < WI_W'(WORDS);
    assign cnt_inc   = &cnt_q ? cnt_q : cnt_q + 32'd1;
    assign addr      = ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx_q, 2'b00});

`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
    logic timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        lane_idx_d = lane_idx_q;
        word_idx_d = word_idx_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
`ifdef LOADER_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        we         = 1'b0;
        wdata      = '0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    state_d = LOAD;
                    if (in_window) begin
                        lane_idx_d = lane_idx_q + 2'd1;
                        if (lane_idx_q == 2'd3) begin
                            we         = 1'b1;
                            wdata      = {in_data, lane_q[23:0]};
                            lane_d     = '0;
                            word_idx_d = word_idx_q + WI_W'(1);
                        end else begin
                            lane_d = lane_q | (32'(in_data) << {lane_idx_q, 3'b000});
                        end
                    end else begin
                        overrun_d = 1'b1;
                    end
                    // a partial word still sits in the lanes and needs its own zero-padded write
                    if (in_last)
                        state_d = (in_window && lane_idx_q != 2'd3) ? FLUSH : START;
                end
            end
            FLUSH: begin
                we         = 1'b1;
                wdata      = lane_q;
                lane_d     = '0;
                lane_idx_d = '0;
                word_idx_d = word_idx_q + WI_W'(1);
                state_d    = START;
            end
            START: begin
                cnt_d   = 32'd1;
                state_d = done_port ? REPORT : RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (done_port)
                    state_d = REPORT;
`ifdef LOADER_TIMEOUT_EN
                else if (cnt_inc >= TO) begin
                    cnt_d     = TO;
                    timeout_d = 1'b1;
                    state_d   = REPORT;
                end
`endif
            end
            REPORT: begin
                if (res_ack) begin
                    state_d    = IDLE;
                    overrun_d  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    word_idx_d = '0;
                    lane_d     = '0;
                    lane_idx_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            lane_idx_q  <= '0;
            word_idx_q  <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            lane_idx_q  <= lane_idx_d;
            word_idx_q  <= word_idx_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
`ifdef LOADER_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
            in_ready_q  <= state_d == IDLE || state_d == LOAD;
            start_q     <= state_d == START;
            res_valid_q <= state_d == REPORT;
        end
    end

    assign in_ready        = in_ready_q;
    assign S_we_ram        = we;
    assign S_addr_ram      = we ? addr : '0;
    assign S_Wdata_ram     = wdata;
    assign S_data_ram_size = we ? 7'd32 : 7'd0;
    assign start_port      = start_q;
    assign res_valid       = res_valid_q;
    assign sim_cycles      = cnt_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_main_mem_loader.sv
// tb_main_mem_loader: directed image loads with hand-computed RAM writes, cycle counts and flags.
module tb_main_mem_loader;
    localparam int BASE = 64;
    localparam int MEMB = 128;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, done_port = 1'b0, res_ack = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, S_we_ram, start_port, res_valid, overrun, timeout;
    logic [8:0]  S_addr_ram;
    logic [31:0] S_Wdata_ram, sim_cycles;
    logic [6:0]  S_data_ram_size;

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, n_start = 0, n_rv = 0, start_cyc = 0, last_wr_cyc = 0;
    logic [8:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  img[$];

    main_mem_loader #(.MEM_BYTES(MEMB), .BASE_ADDR(BASE), .ADDR_W(9), .TIMEOUT_CYCLES(50)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size), .start_port(start_port), .done_port(done_port),
        .res_valid(res_valid), .res_ack(res_ack), .sim_cycles(sim_cycles), .overrun(overrun),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (S_we_ram) begin
            wr_addr.push_back(S_addr_ram);
            wr_data.push_back(S_Wdata_ram);
            last_wr_cyc = cyc;
            check("wr_size", 64'(S_data_ram_size), 64'd32);
        end
        if (start_port) begin
            n_start++;
            start_cyc = cyc;
        end
        if (res_valid) n_rv++;
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        n_start = 0;
        n_rv = 0;
    endtask

    task automatic send();
        for (int i = 0; i < img.size(); i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_data  = img[i];
            in_last  = (i == img.size() - 1);
            while (!in_ready && t < 100) begin
                @(posedge clock); #1;
                t++;
            end
            if (t == 100) check("ready_wait", 64'd0, 64'd1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (!start_port && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (t == 100) check("start_wait", 64'd0, 64'd1);
    endtask

    task automatic acc(input int lat);
        wait_start();
        repeat (lat) begin
            @(posedge clock); #1;
        end
        done_port = 1'b1;
        @(posedge clock); #1;
        done_port = 1'b0;
    endtask

    task automatic report(input logic [31:0] exp_cyc, input logic exp_ovr, input logic exp_to);
        int t = 0;
        while (!res_valid && t < 500) begin
            @(posedge clock); #1;
            t++;
        end
        check("res_valid", 64'(res_valid), 64'd1);
        check("sim_cycles", 64'(sim_cycles), 64'(exp_cyc));
        check("overrun", 64'(overrun), 64'(exp_ovr));
        check("timeout", 64'(timeout), 64'(exp_to));
        check("ready_in_report", 64'(in_ready), 64'd0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("res_valid_held", 64'(res_valid), 64'd1);
        check("sim_cycles_held", 64'(sim_cycles), 64'(exp_cyc));
        res_ack  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clock); #1;
        res_ack  = 1'b0;
        in_valid = 1'b0;
        check("res_valid_ack", 64'(res_valid), 64'd0);
        check("overrun_clr", 64'(overrun), 64'd0);
        check("ready_idle", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(S_we_ram), 64'd0);
        check("rst_addr", 64'(S_addr_ram), 64'd0);
        check("rst_size", 64'(S_data_ram_size), 64'd0);
        check("rst_start", 64'(start_port), 64'd0);
        check("rst_rv", 64'(res_valid), 64'd0);
        check("rst_cycles", 64'(sim_cycles), 64'd0);
        check("rst_flags", {62'd0, overrun, timeout}, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // full words, start after last write
        clear_mon();
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send();
        acc(10);
        report(32'd11, 1'b0, 1'b0);
        check("t1_nwr", 64'(wr_addr.size()), 64'd2);
        check("t1_a0", 64'(wr_addr[0]), 64'(BASE));
        check("t1_d0", 64'(wr_data[0]), 64'h04030201);
        check("t1_a1", 64'(wr_addr[1]), 64'(BASE + 4));
        check("t1_d1", 64'(wr_data[1]), 64'h08070605);
        check("t1_nstart", 64'(n_start), 64'd1);
        check("t1_order", 64'(start_cyc > last_wr_cyc), 64'd1);

        // partial last word flushed with zero padding; ack-cycle byte must not leak in
        clear_mon();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send();
        acc(0);
        report(32'd1, 1'b0, 1'b0);
        check("t2_nwr", 64'(wr_addr.size()), 64'd2);
        check("t2_d0", 64'(wr_data[0]), 64'hDDCCBBAA);
        check("t2_a1", 64'(wr_addr[1]), 64'(BASE + 4));
        check("t2_d1", 64'(wr_data[1]), 64'h000000EE);
        check("t2_nstart", 64'(n_start), 64'd1);
        check("t2_order", 64'(start_cyc > last_wr_cyc), 64'd1);

        // overrun past the window
        clear_mon();
        img.delete();
        for (int i = 0; i < 132; i++) img.push_back(8'(i));
        send();
        acc(3);
        report(32'd4, 1'b1, 1'b0);
        check("t3_nwr", 64'(wr_addr.size()), 64'd32);
        check("t3_d0", 64'(wr_data[0]), 64'h03020100);
        check("t3_alast", 64'(wr_addr[31]), 64'(BASE + 124));
        check("t3_dlast", 64'(wr_data[31]), 64'h7F7E7D7C);

        // reset mid-run, then a fresh image restarts at the base
        clear_mon();
        img = '{8'h55, 8'h66, 8'h77, 8'h88};
        send();
        wait_start();
        repeat (5) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_cycles", 64'(sim_cycles), 64'd0);
        check("abort_start", 64'(start_port), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        clear_mon();
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        send();
        check("abort_no_rv", 64'(n_rv), 64'd0);
        acc(2);
        report(32'd3, 1'b0, 1'b0);
        check("t4_a0", 64'(wr_addr[0]), 64'(BASE));
        check("t4_d0", 64'(wr_data[0]), 64'h44332211);

`ifdef LOADER_TIMEOUT_EN
        clear_mon();
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        send();
        wait_start();
        report(32'd50, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
